// File: rtl/mci_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between cache requesters,
// with a per-transaction watchdog that aborts stalled transfers and raises a sticky error.
package mci_pkg;
  parameter int unsigned MCI_AW = 32;
  parameter int unsigned MCI_DW = 32;

  typedef struct packed {
    logic [MCI_AW-1:0] addr;
    logic [MCI_DW-1:0] data;
    logic              rw;
    logic              valid;
  } mci_request_t;

  typedef struct packed {
    logic [MCI_DW-1:0] data;
    logic              ready;
  } mci_response_t;
endpackage

// state | meaning
// IDLE  | no transaction outstanding, arbitrating among valid requesters
// BUSY  | mem_req_o held for grant_idx_o until response or watchdog abort
module mci_arbiter
  import mci_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  mci_request_t               req_i [N_REQ],
  output mci_response_t              rsp_o [N_REQ],
  output mci_request_t               mem_req_o,
  input  mci_response_t              mem_rsp_i,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
  output logic                       err_timeout_o,
  input  logic                       err_clr_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic             timeout_hit;

  // A response arriving in the trigger cycle completes normally instead of aborting.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == BUSY) &&
                       (cnt == CNT_LAST) && !mem_rsp_i.ready;

  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDX_W'(j);
      if (!found && req_i[jj].valid) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) rsp_o[i] = '0;
    if (state == BUSY) begin
      rsp_o[grant_idx_o].ready = mem_rsp_i.ready | timeout_hit;
      rsp_o[grant_idx_o].data  = timeout_hit ? '0 : mem_rsp_i.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req_o     <= '0;
      busy_o        <= 1'b0;
      grant_idx_o   <= '0;
      err_timeout_o <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      if (timeout_hit)    err_timeout_o <= 1'b1;
      else if (err_clr_i) err_timeout_o <= 1'b0;

      case (state)
        IDLE: begin
          mem_req_o.valid <= 1'b0;
          if (found) begin
            mem_req_o.addr  <= req_i[pick].addr;
            mem_req_o.data  <= req_i[pick].data;
            mem_req_o.rw    <= req_i[pick].rw;
            mem_req_o.valid <= 1'b1;
            grant_idx_o     <= pick;
            busy_o          <= 1'b1;
            cnt             <= '0;
            ptr             <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (mem_rsp_i.ready || timeout_hit) begin
            mem_req_o.valid <= 1'b0;
            busy_o          <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
